// File: rtl/mux_pkg.sv
// Shared constants and types for the bit-sliced 32:1 selector tree.
package mux_pkg;
  localparam int NUM_LANES  = 32;
  localparam int SEL_W      = 5;
  localparam int HALF_LANES = 16;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux16_1.sv
// Single-bit 16:1 selector built as four levels of 2:1 cells (8/4/2/1),
// selection[0] at the leaves and selection[3] at the root.
module mux16_1
  import mux_pkg::*;
(
  input  logic [HALF_LANES-1:0] in_signal,
  input  logic [3:0]            selection,
  output logic                  out
);
  logic [7:0] lvl1;
  logic [3:0] lvl2;
  logic [1:0] lvl3;

  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    mux2_1 u_mux (.i0(in_signal[2*i]), .i1(in_signal[2*i+1]), .sel(selection[0]), .out(lvl1[i]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl2
    mux2_1 u_mux (.i0(lvl1[2*i]), .i1(lvl1[2*i+1]), .sel(selection[1]), .out(lvl2[i]));
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl3
    mux2_1 u_mux (.i0(lvl2[2*i]), .i1(lvl2[2*i+1]), .sel(selection[2]), .out(lvl3[i]));
  end

  mux2_1 u_root (.i0(lvl3[0]), .i1(lvl3[1]), .sel(selection[3]), .out(out));
endmodule

// File: rtl/mux2_1.sv
// Single-bit 2:1 selector; the leaf cell of every selection tree.
module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic out
);
  // A known sel returns only the chosen operand, so X on the other input stays out.
  assign out = sel ? i1 : i0;
endmodule

// File: rtl/mux_32to1.sv
// Bit-sliced 32:1 lane selector: two 16:1 half-trees per bit plus a final 2:1,
// with an optional enable-loaded output register for pipelined consumers.
module mux_32to1
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_LANES*WIDTH-1:0] in_signal,
  input  sel_t                       selection,
  input  logic                       en,
  output logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           out_q,
  output logic                       valid_q
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    logic [HALF_LANES-1:0] lo_bits;
    logic [HALF_LANES-1:0] hi_bits;
    logic                  lo_out;
    logic                  hi_out;

    // Gather bit b of every lane so each slice only ever sees one bit position.
    for (genvar i = 0; i < HALF_LANES; i++) begin : g_gather
      assign lo_bits[i] = in_signal[i*WIDTH + b];
      assign hi_bits[i] = in_signal[(i+HALF_LANES)*WIDTH + b];
    end

    mux16_1 u_lo (.in_signal(lo_bits), .selection(selection[3:0]), .out(lo_out));
    mux16_1 u_hi (.in_signal(hi_bits), .selection(selection[3:0]), .out(hi_out));
    mux2_1  u_fin (.i0(lo_out), .i1(hi_out), .sel(selection[4]), .out(out[b]));
  end

  // en is a plain load strobe; valid_q marks that out_q holds a capture made since reset.
  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else if (en) begin
        out_q   <= out;
        valid_q <= 1'b1;
      end
    end
  end else begin : g_noreg
    assign out_q   = '0;
    assign valid_q = 1'b0;
  end
endmodule

// File: tb/tb_mux_32to1.sv
// Directed and swept checks of mux_32to1 at WIDTH=1 and WIDTH=8, including
// the output register, asynchronous reset and the unregistered variant.
module tb_mux_32to1;
  logic         clk;
  logic         reset_n;

  logic [31:0]  in1;
  logic [4:0]   sel1;
  logic         en1;
  logic         out1;
  logic         out1_q;
  logic         valid1_q;

  logic [255:0] in8;
  logic [4:0]   sel8;
  logic         en8;
  logic [7:0]   out8;
  logic [7:0]   out8_q;
  logic         valid8_q;

  logic [7:0]   outn;
  logic [7:0]   outn_q;
  logic         validn_q;

  int total;
  int bad;

  mux_32to1 #(.WIDTH(1), .REG_OUT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_signal(in1), .selection(sel1), .en(en1),
    .out(out1), .out_q(out1_q), .valid_q(valid1_q)
  );

  mux_32to1 #(.WIDTH(8), .REG_OUT(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_signal(in8), .selection(sel8), .en(en8),
    .out(out8), .out_q(out8_q), .valid_q(valid8_q)
  );

  mux_32to1 #(.WIDTH(8), .REG_OUT(0)) dutn (
    .clk(clk), .reset_n(reset_n), .in_signal(in8), .selection(sel8), .en(en8),
    .out(outn), .out_q(outn_q), .valid_q(validn_q)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive1(input logic [31:0] v, input logic [4:0] s);
    in1  = v;
    sel1 = s;
    #1;
  endtask

  task automatic set_lane8(input logic [4:0] s, input logic [7:0] v);
    in8[s*8 +: 8] = v;
  endtask

  initial begin
    logic [31:0]  v;
    logic [4:0]   s;
    logic [7:0]   lane;
    logic [31:0]  xin;

    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    in1 = '0; sel1 = '0; en1 = 1'b0;
    in8 = '0; sel8 = '0; en8 = 1'b0;
    #2;

    check("reset_out1_q",  {31'd0, out1_q},   32'd0);
    check("reset_valid1",  {31'd0, valid1_q}, 32'd0);
    check("reset_out8_q",  {24'd0, out8_q},   32'd0);
    check("reset_valid8",  {31'd0, valid8_q}, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;

    // one-hot and one-cold sweeps
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 32; j++) begin
        v = 32'd1 << k;
        drive1(v, 5'(j));
        check("onehot", {31'd0, out1}, (j == k) ? 32'd1 : 32'd0);
        drive1(~v, 5'(j));
        check("onecold", {31'd0, out1}, (j == k) ? 32'd0 : 32'd1);
      end
    end

    // half-tree boundaries
    drive1(32'h0001_8000, 5'd15); check("bound_15", {31'd0, out1}, 32'd1);
    drive1(32'h0001_8000, 5'd16); check("bound_16", {31'd0, out1}, 32'd1);
    drive1(32'h0001_8000, 5'd14); check("bound_14", {31'd0, out1}, 32'd0);
    drive1(32'h0001_8000, 5'd17); check("bound_17", {31'd0, out1}, 32'd0);

    // random sweeps against a shift-and-mask lane reference
    for (int n = 0; n < 1000; n++) begin
      v = $urandom;
      s = 5'($urandom_range(0, 31));
      drive1(v, s);
      check("rand_w1", {31'd0, out1}, {31'd0, v[s]});
    end
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 8; w++) in8[w*32 +: 32] = $urandom;
      sel8 = 5'($urandom_range(0, 31));
      #1;
      lane = 8'((in8 >> (32'(sel8) * 8)) & 256'hFF);
      check("rand_w8", {24'd0, out8}, {24'd0, lane});
      check("rand_noreg_out", {24'd0, outn}, {24'd0, lane});
    end

    // registers must still hold reset values: en has been low throughout
    check("hold_reset_q8", {24'd0, out8_q}, 32'd0);
    check("hold_reset_v8", {31'd0, valid8_q}, 32'd0);

    // capture and hold
    @(negedge clk);
    in8  = '0;
    sel8 = 5'd3;
    set_lane8(5'd3, 8'hA5);
    en8  = 1'b1;
    @(posedge clk); #1;
    check("cap_out_q", {24'd0, out8_q}, 32'h0000_00A5);
    check("cap_valid", {31'd0, valid8_q}, 32'd1);
    check("noreg_out_q", {24'd0, outn_q}, 32'd0);
    check("noreg_valid", {31'd0, validn_q}, 32'd0);

    @(negedge clk);
    en8 = 1'b0;
    set_lane8(5'd3, 8'h3C);
    @(posedge clk); #1;
    check("hold_out_q", {24'd0, out8_q}, 32'h0000_00A5);
    check("hold_valid", {31'd0, valid8_q}, 32'd1);
    check("hold_out",   {24'd0, out8},   32'h0000_003C);

    // asynchronous reset between edges
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_out_q", {24'd0, out8_q}, 32'd0);
    check("arst_valid", {31'd0, valid8_q}, 32'd0);
    set_lane8(5'd3, 8'h77);
    #1;
    check("arst_out_live", {24'd0, out8}, 32'h0000_0077);

    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_out_q", {24'd0, out8_q}, 32'd0);
    check("rel_valid", {31'd0, valid8_q}, 32'd0);

    @(negedge clk);
    en8 = 1'b1;
    @(posedge clk); #1;
    check("recap_out_q", {24'd0, out8_q}, 32'h0000_0077);
    check("recap_valid", {31'd0, valid8_q}, 32'd1);
    @(negedge clk);
    en8 = 1'b0;

    // unknowns on unselected lanes must not reach out
    xin = {32{1'bx}};
    xin[5] = 1'b1;
    drive1(xin, 5'd5);
    check("isolate_x", {31'd0, out1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
